// File: rtl/sweep_pkg.sv
// Shared definitions for the sweep sequencer: FSM state encoding, minimum tick period, ticks-per-pass helpers.
// Latency: none (constants and constant functions only).
// Backpressure: not applicable.
package sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_RUN    = 2'd2,
        ST_FINISH = 2'd3
    } sweep_state_e;

    // Smallest legal tick period; guarantees a low cycle after every tick.
    localparam int SWEEP_MIN_PERIOD = 2;

    // One full back-and-forth sweep of a WIDTH-bit mask takes 2*(WIDTH-1) shifts.
    function automatic int sweep_ticks_per_pass(input int width);
        return 2 * (width - 1);
    endfunction

    // Width of the tick counter that spans 0 .. ticks_per_pass-1.
    function automatic int sweep_tick_cnt_w(input int width);
        int w;
        w = $clog2(2 * (width - 1));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sweep_period_timer.sv
// Loadable down-counter that paces engine ticks; tc_o pulses in the cycle the count reaches zero.
// Latency: tc_o is registered and asserts one cycle after the advance that lands on zero.
// Backpressure: hold_i freezes the count; a zero count reloads automatically on the next advance.
module sweep_period_timer
    import sweep_pkg::*;
#(
    parameter int PERIOD_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic                hold_i,
    input  logic [PERIOD_W-1:0] reload_i,
    output logic                tc_o
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                tc_q, tc_d;

    // Next count: explicit load wins, otherwise step down (reloading from zero) unless held.
    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        if (load_i) begin
            cnt_d = reload_i;
        end else if (!hold_i) begin
            cnt_d = (cnt_q == '0) ? reload_i : cnt_q - 1'b1;
            tc_d  = (cnt_d == '0);
        end
    end

    // Count and terminal-count registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    assign tc_o = tc_q;

endmodule

// File: rtl/sweep_sequencer.sv
// Command-driven sequencer: enables a sweep-mask engine, ticks it every period cycles, stops after N passes.
// Latency: enable rises the cycle after command accept; first tick period cycles later; all outputs registered.
// Backpressure: cmd_ready_o is high only in IDLE; commands offered while busy are dropped, not queued.
// Optional: SWEEP_SEQUENCER_PAUSE_EN adds pause_i, which freezes tick pacing while running.
module sweep_sequencer
    import sweep_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PERIOD_W = 16,
    parameter int PASS_W   = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
`ifdef SWEEP_SEQUENCER_PAUSE_EN
    input  logic                pause_i,
`endif
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [PERIOD_W-1:0] cmd_period_i,
    input  logic [PASS_W-1:0]   cmd_passes_i,
    input  logic                abort_i,
    output logic                en_o,
    output logic                tick_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [PASS_W-1:0]   pass_cnt_o
);

    localparam int                  TPP        = sweep_ticks_per_pass(WIDTH);
    localparam int                  TICK_W     = sweep_tick_cnt_w(WIDTH);
    localparam logic [TICK_W-1:0]   TICK_LAST  = TICK_W'(TPP - 1);
    localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(SWEEP_MIN_PERIOD);

    sweep_state_e        state_q, state_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PASS_W-1:0]   passes_q, passes_d;
    logic [PASS_W-1:0]   pass_cnt_q, pass_cnt_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic                en_q, busy_q, ready_q, done_q, done_d;
    logic                timer_load, timer_hold, tick;
    logic                pause_w;
    logic [PERIOD_W-1:0] reload_val;

`ifdef SWEEP_SEQUENCER_PAUSE_EN
    assign pause_w = pause_i;
`else
    assign pause_w = 1'b0;
`endif

    assign reload_val = period_q - 1'b1;

    sweep_period_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (timer_load),
        .hold_i   (timer_hold),
        .reload_i (reload_val),
        .tc_o     (tick)
    );

    // Next-state logic: command capture, tick/pass accounting, completion and abort handling.
    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        passes_d   = passes_q;
        pass_cnt_d = pass_cnt_q;
        tick_cnt_d = tick_cnt_q;
        done_d     = 1'b0;
        timer_load = 1'b0;
        timer_hold = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && ready_q) begin
                    period_d   = (cmd_period_i < MIN_PERIOD) ? MIN_PERIOD : cmd_period_i;
                    passes_d   = cmd_passes_i;
                    pass_cnt_d = '0;
                    tick_cnt_d = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    timer_load = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort beats both pause and a completing tick; pass count is left as is.
                if (abort_i) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    timer_hold = pause_w;
                    if (tick) begin
                        if (tick_cnt_q == TICK_LAST) begin
                            tick_cnt_d = '0;
                            pass_cnt_d = pass_cnt_q + 1'b1;
                            if ((passes_q != '0) && (pass_cnt_d == passes_q)) begin
                                state_d    = ST_FINISH;
                                timer_hold = 1'b1;
                            end
                        end else begin
                            tick_cnt_d = tick_cnt_q + 1'b1;
                        end
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, run context and registered outputs derived from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            period_q   <= MIN_PERIOD;
            passes_q   <= '0;
            pass_cnt_q <= '0;
            tick_cnt_q <= '0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            passes_q   <= passes_d;
            pass_cnt_q <= pass_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            en_q       <= (state_d != ST_IDLE);
            busy_q     <= (state_d != ST_IDLE);
            ready_q    <= (state_d == ST_IDLE);
            done_q     <= done_d;
        end
    end

    assign cmd_ready_o = ready_q;
    assign en_o        = en_q;
    assign tick_o      = tick;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_cnt_o  = pass_cnt_q;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Self-checking bench for sweep_sequencer against a cycle-offset reference model.
// Latency: checks every cycle of each run relative to the accept cycle.
// Backpressure: exercises commands offered while busy and accept in the done cycle.
module tb_sweep_sequencer;

    localparam int WIDTH    = 4;
    localparam int PERIOD_W = 16;
    localparam int PASS_W   = 8;
    localparam int TPP      = 2 * (WIDTH - 1);

    typedef logic [PASS_W+4:0] obs_t; // {en, tick, done, busy, ready, pass_cnt}

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                cmd_valid_i;
    logic                cmd_ready_o;
    logic [PERIOD_W-1:0] cmd_period_i;
    logic [PASS_W-1:0]   cmd_passes_i;
    logic                abort_i;
    logic                en_o, tick_o, busy_o, done_o;
    logic [PASS_W-1:0]   pass_cnt_o;
`ifdef SWEEP_SEQUENCER_PAUSE_EN
    logic                pause_i;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    sweep_sequencer #(
        .WIDTH    (WIDTH),
        .PERIOD_W (PERIOD_W),
        .PASS_W   (PASS_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
`ifdef SWEEP_SEQUENCER_PAUSE_EN
        .pause_i      (pause_i),
`endif
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_period_i (cmd_period_i),
        .cmd_passes_i (cmd_passes_i),
        .abort_i      (abort_i),
        .en_o         (en_o),
        .tick_o       (tick_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .pass_cnt_o   (pass_cnt_o)
    );

    // Expected outputs d cycles after the accept cycle of an uninterrupted run.
    function automatic obs_t model(input int d, input int p, input int passes);
        int   pe, n, tb;
        logic en, tk, dn;
        pe = (p < 2) ? 2 : p;
        n  = passes * TPP;
        en = (d >= 1) && (passes == 0 || d <= n * pe + 2);
        tk = (d >= 2) && ((d - 1) % pe == 0) && (passes == 0 || (d - 1) / pe <= n);
        dn = (passes != 0) && (d == n * pe + 3);
        tb = (d < 2) ? 0 : (d - 2) / pe;
        if (passes != 0 && tb > n) tb = n;
        tb = (tb / TPP) % (1 << PASS_W);
        return {en, tk, dn, en, ~en, tb[PASS_W-1:0]};
    endfunction

    function automatic obs_t observe();
        return {en_o, tick_o, done_o, busy_o, cmd_ready_o, pass_cnt_o};
    endfunction

    // Offer one command; returns just after the accepting edge.
    task automatic start_cmd(input int p, input int passes);
        cmd_period_i = PERIOD_W'(p);
        cmd_passes_i = PASS_W'(passes);
        cmd_valid_i  = 1'b1;
        @(posedge clk_i);
        #1 cmd_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        obs_t exp;
        exp = {5'b00001, {PASS_W{1'b0}}};
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (observe() !== exp) begin
            errors++;
            $display("FAIL reset_held got=%h exp=%h", observe(), exp);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (observe() !== exp) begin
            errors++;
            $display("FAIL reset_release got=%h exp=%h", observe(), exp);
        end
    endtask

    task automatic test_basic();
        obs_t exp;
        int   ticks;
        ticks = 0;
        start_cmd(3, 1);
        for (int d = 1; d <= 22; d++) begin
            @(negedge clk_i);
            exp = model(d, 3, 1);
            if (tick_o) ticks++;
            checks++;
            if (observe() !== exp) begin
                errors++;
                $display("FAIL basic d=%0d got=%h exp=%h", d, observe(), exp);
            end
        end
        checks++;
        if (ticks !== 6) begin
            errors++;
            $display("FAIL basic_tick_total got=%0d exp=6", ticks);
        end
    endtask

    task automatic test_clamp();
        obs_t exp;
        start_cmd(0, 1);
        for (int d = 1; d <= 16; d++) begin
            @(negedge clk_i);
            exp = model(d, 0, 1);
            checks++;
            if (observe() !== exp) begin
                errors++;
                $display("FAIL clamp d=%0d got=%h exp=%h", d, observe(), exp);
            end
        end
    endtask

    task automatic test_continuous();
        obs_t exp;
        start_cmd(2, 0);
        for (int d = 1; d <= 62; d++) begin
            @(negedge clk_i);
            exp = model(d, 2, 0);
            checks++;
            if (observe() !== exp) begin
                errors++;
                $display("FAIL continuous d=%0d got=%h exp=%h", d, observe(), exp);
            end
        end
        abort_i = 1'b1;
        @(negedge clk_i);
        exp = {5'b00101, PASS_W'(5)};
        checks++;
        if (observe() !== exp) begin
            errors++;
            $display("FAIL continuous_abort got=%h exp=%h", observe(), exp);
        end
        abort_i = 1'b0;
        @(negedge clk_i);
        exp = {5'b00001, PASS_W'(5)};
        checks++;
        if (observe() !== exp) begin
            errors++;
            $display("FAIL continuous_after_abort got=%h exp=%h", observe(), exp);
        end
    endtask

    task automatic test_back_to_back();
        obs_t exp;
        cmd_period_i = PERIOD_W'(2);
        cmd_passes_i = PASS_W'(2);
        cmd_valid_i  = 1'b1;
        @(posedge clk_i);
        for (int d = 1; d <= 27; d++) begin
            @(negedge clk_i);
            exp = model(d, 2, 2);
            checks++;
            if (observe() !== exp) begin
                errors++;
                $display("FAIL b2b_first d=%0d got=%h exp=%h", d, observe(), exp);
            end
            if (d == 26) begin
                cmd_period_i = PERIOD_W'(4);
                cmd_passes_i = PASS_W'(1);
            end
        end
        @(posedge clk_i);
        #1 cmd_valid_i = 1'b0;
        for (int d = 1; d <= 28; d++) begin
            @(negedge clk_i);
            exp = model(d, 4, 1);
            checks++;
            if (observe() !== exp) begin
                errors++;
                $display("FAIL b2b_second d=%0d got=%h exp=%h", d, observe(), exp);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        obs_t exp;
        start_cmd(3, 1);
        for (int d = 1; d <= 8; d++) begin
            @(negedge clk_i);
            exp = model(d, 3, 1);
            checks++;
            if (observe() !== exp) begin
                errors++;
                $display("FAIL midreset_run d=%0d got=%h exp=%h", d, observe(), exp);
            end
        end
        rst_i = 1'b1;
        exp   = {5'b00001, {PASS_W{1'b0}}};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            rst_i = 1'b0;
            checks++;
            if (observe() !== exp) begin
                errors++;
                $display("FAIL midreset_after k=%0d got=%h exp=%h", k, observe(), exp);
            end
        end
    endtask

    task automatic test_abort_final_tick();
        obs_t exp;
        logic [PASS_W-1:0] held;
        held = '0;
        start_cmd(2, 1);
        for (int d = 1; d <= 13; d++) begin
            @(negedge clk_i);
            exp  = model(d, 2, 1);
            held = exp[PASS_W-1:0];
            checks++;
            if (observe() !== exp) begin
                errors++;
                $display("FAIL abort_final_run d=%0d got=%h exp=%h", d, observe(), exp);
            end
        end
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        exp = {5'b00101, held};
        checks++;
        if (observe() !== exp) begin
            errors++;
            $display("FAIL abort_final got=%h exp=%h", observe(), exp);
        end
    endtask

    task automatic test_random();
        obs_t exp;
        logic [PASS_W-1:0] held;
        int p, passes, pe, dn, ab;
        logic aborted;
        for (int it = 0; it < 8; it++) begin
            p       = $urandom_range(0, 5);
            passes  = $urandom_range(1, 3);
            pe      = (p < 2) ? 2 : p;
            dn      = passes * TPP * pe + 3;
            ab      = ($urandom_range(0, 1) == 1) ? $urandom_range(1, dn - 1) : 0;
            aborted = 1'b0;
            held    = '0;
            start_cmd(p, passes);
            for (int d = 1; d <= dn + 1; d++) begin
                @(negedge clk_i);
                if (aborted) begin
                    abort_i = 1'b0;
                    exp = {5'b00101, held};
                    checks++;
                    if (observe() !== exp) begin
                        errors++;
                        $display("FAIL random_abort it=%0d p=%0d n=%0d ab=%0d got=%h exp=%h",
                                 it, p, passes, ab, observe(), exp);
                    end
                    break;
                end
                exp = model(d, p, passes);
                checks++;
                if (observe() !== exp) begin
                    errors++;
                    $display("FAIL random it=%0d p=%0d n=%0d d=%0d got=%h exp=%h",
                             it, p, passes, d, observe(), exp);
                end
                if (d == ab) begin
                    abort_i = 1'b1;
                    aborted = 1'b1;
                    held    = exp[PASS_W-1:0];
                end
            end
        end
    endtask

`ifdef SWEEP_SEQUENCER_PAUSE_EN
    task automatic test_pause();
        logic exp_t, exp_en, exp_dn;
        int   ticks;
        ticks = 0;
        start_cmd(3, 1);
        for (int d = 1; d <= 27; d++) begin
            @(negedge clk_i);
            exp_t  = (d == 4 || d == 12 || d == 15 || d == 18 || d == 21 || d == 24);
            exp_en = (d <= 25);
            exp_dn = (d == 26);
            if (tick_o) ticks++;
            checks++;
            if ({en_o, tick_o, done_o} !== {exp_en, exp_t, exp_dn}) begin
                errors++;
                $display("FAIL pause d=%0d got=%b exp=%b", d, {en_o, tick_o, done_o},
                         {exp_en, exp_t, exp_dn});
            end
            pause_i = (d >= 6 && d <= 10);
        end
        checks++;
        if (ticks !== 6) begin
            errors++;
            $display("FAIL pause_tick_total got=%0d exp=6", ticks);
        end
        checks++;
        if (pass_cnt_o !== PASS_W'(1)) begin
            errors++;
            $display("FAIL pause_pass_cnt got=%0d exp=1", pass_cnt_o);
        end
    endtask
`endif

    initial begin
        rst_i        = 1'b1;
        cmd_valid_i  = 1'b0;
        cmd_period_i = '0;
        cmd_passes_i = '0;
        abort_i      = 1'b0;
`ifdef SWEEP_SEQUENCER_PAUSE_EN
        pause_i      = 1'b0;
`endif
        test_reset();
        test_basic();
        test_clamp();
        test_continuous();
        test_back_to_back();
        test_reset_mid_run();
        test_abort_final_tick();
        test_random();
`ifdef SWEEP_SEQUENCER_PAUSE_EN
        test_pause();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sweep_sequencer.md
Name: sweep_sequencer

Overview:
- Command-driven controller that sequences one sweep-mask engine by driving its enable and tick inputs.
- Accepts a {period, passes} command over a valid/ready handshake and enables the engine.
- Issues single-cycle ticks every `period` cycles, counts full back-and-forth passes, then disables the engine and pulses done.
- Sits between the register/config layer and the sweep-mask engine in the pulse-generator datapath.

Parameters:
- WIDTH, 4: mask width of the driven sweep engine; must be >= 2. Ticks per pass = 2*(WIDTH-1).
- PERIOD_W, 16: width of the tick period field, in clock cycles.
- PASS_W, 8: width of the pass-count field and pass counter.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- cmd_valid_i  input  1  command valid.
- cmd_ready_o  output  1  high only in IDLE.
- cmd_period_i  input  PERIOD_W  cycles between ticks; values 0 and 1 are clamped to 2.
- cmd_passes_i  input  PASS_W  full passes to run; 0 means continuous until abort.
- abort_i  input  1  stop the current run.
- en_o  output  1  engine enable.
- tick_o  output  1  engine tick, one cycle wide.
- busy_o  output  1  high in every state except IDLE.
- done_o  output  1  one-cycle pulse on run completion or abort.
- pass_cnt_o  output  PASS_W  completed passes in the current or last run.

Behaviour:
- All outputs are registered.
- Reset (rst_i=1, synchronous) forces:
  - state=IDLE
  - en_o=0, tick_o=0, busy_o=0, done_o=0, pass_cnt_o=0
  - cmd_ready_o=1
  - internal counters cleared
- Reset mid-run aborts immediately with no done pulse.
- States: IDLE, START, RUN, FINISH.
- IDLE:
  - cmd_ready_o=1.
  - On accept in cycle T (cmd_valid_i & cmd_ready_o):
    - latch period (clamped) and passes
    - clear pass_cnt_o and the tick counter
    - go to START
  - abort_i is ignored in IDLE.
- START (cycle T+1):
  - en_o=1, busy_o=1, so the engine loads its initial mask.
  - Load the period down-counter with period-1, go to RUN.
- RUN:
  - en_o=1.
  - Counter decrements each cycle. On reaching 0: tick_o=1 for that cycle and counter reloads to period-1.
  - Resulting tick timing:
    - First tick at cycle T+1+period.
    - Later ticks every `period` cycles.
    - tick_o is always followed by at least one low cycle (minimum period 2 guarantees this).
  - Tick counter counts 0 .. 2*(WIDTH-1)-1. On wrap, pass_cnt_o increments.
  - pass_cnt_o wraps modulo 2^PASS_W in continuous mode.
  - When passes != 0 and the completing tick makes pass_cnt_o == passes, go to FINISH.
- FINISH:
  - One cycle with en_o=1 and tick_o=0, so the engine completes its final shift.
  - Then IDLE with en_o=0 and done_o=1 for one cycle.
- Abort (abort_i=1 in START/RUN/FINISH):
  - Next cycle: IDLE, en_o=0, tick_o=0, done_o=1.
  - pass_cnt_o holds its value.
  - A tick scheduled in the abort cycle is suppressed.
- Simultaneous events:
  - abort_i together with a final tick: abort wins, no FINISH cycle.
  - cmd_valid_i while busy is ignored; it is not queued.
- done_o and cmd_ready_o are both high in the first IDLE cycle. A new command may be accepted in that same cycle.

Optional Feature:
- Macro SWEEP_SEQUENCER_PAUSE_EN.
- Defined: adds input pause_i (1 bit).
  - While pause_i=1 in RUN, the period counter and tick counter hold, tick_o=0 and en_o stays 1.
  - A tick due during pause fires in the first cycle after pause_i falls.
  - abort_i overrides pause_i.
- Undefined: port absent; behaviour identical to pause_i tied to 0.

Decomposition:
- Package sweep_pkg holds:
  - state encoding constants (IDLE/START/RUN/FINISH)
  - SWEEP_MIN_PERIOD=2
  - ticks-per-pass expression 2*(WIDTH-1) and its counter width $clog2(2*(WIDTH-1))
- One sub-module, sweep_period_timer:
  - loadable PERIOD_W down-counter with hold input and terminal-count pulse.
  - Instantiated once by the FSM.

Test Plan:
- Reset, then WIDTH=4, command period=3, passes=1 accepted at T -> en_o rises at T+1; ticks at T+4,7,10,13,16,19 (6 ticks); FINISH at T+20; en_o=0 and done_o=1 at T+21; pass_cnt_o=1.
- Command period=0 -> period is clamped to 2: ticks every 2 cycles, each tick followed by a low cycle.
- passes=0, period=2, run for 30 ticks -> pass_cnt_o=5 and en_o still 1; abort_i asserted -> next cycle en_o=0, done_o=1, pass_cnt_o=5.
- cmd_valid_i held high throughout a passes=2 run -> no re-accept while busy; the next command is accepted in the done_o cycle and en_o rises in the following cycle.
- rst_i asserted mid-RUN -> next cycle all outputs at reset values, no done_o pulse.
- With SWEEP_SEQUENCER_PAUSE_EN defined: pause_i high for 5 cycles spanning a due tick -> the tick is delayed to the first cycle after pause_i falls, and the tick total per pass is still 6.
